micro_div_unit: RTL and testbench
=================================

MICRO_DIV_UNIT -- requirements
Module: micro_div_unit

Interface
REQ-001: Parameter DW, default 8, SHALL set the dividend and quotient width in bits.
REQ-002: Parameter VW, default 4, SHALL set the divisor and remainder width in bits (VW < DW).
REQ-003: sys_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: sys_rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005: start  input  1  SHALL request a division; sampled only in IDLE.
REQ-006: dividend  input  DW  SHALL be the unsigned dividend, captured on an accepted start.
REQ-007: divisor  input  VW  SHALL be the unsigned divisor, captured on an accepted start.
REQ-008: busy  output  1  SHALL be high in RUN and DONE.
REQ-009: done  output  1  SHALL be a one-cycle pulse marking valid results.
REQ-010: quotient  output  DW  SHALL be the unsigned quotient.
REQ-011: remainder  output  VW  SHALL be the unsigned remainder.
REQ-012: dbz  output  1  SHALL flag divide-by-zero for the last completed operation.

Function
REQ-013: The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014: In IDLE with start=1 and divisor!=0, the block SHALL latch the operands, clear the partial remainder, load the bit counter with DW, and go to RUN.
REQ-015: In IDLE with start=1 and divisor=0, the block SHALL go directly to DONE with quotient=all ones, remainder=all ones, and dbz=1.
REQ-016: In RUN, each cycle SHALL perform one restoring step: shift the (VW+1)-bit partial remainder left, inserting the dividend MSB; shift the dividend register left. If the partial remainder >= divisor, subtract the divisor and shift in quotient bit 1, else shift in 0.
REQ-017: The bit counter SHALL decrement once per RUN cycle; after the DW-th step the FSM SHALL go to DONE.
REQ-018: In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-019: For a nonzero divisor, the latency SHALL be fixed: with start accepted at edge N, done is high during the cycle after edge N+DW+1. For a zero divisor, done is high after edge N+1.
REQ-020: quotient, remainder, and dbz SHALL be updated when DONE is entered and held stable until the next accepted start completes.
REQ-021: dbz SHALL be 0 for any completed operation with a nonzero divisor.
REQ-022: start SHALL be ignored while busy=1; operand changes after acceptance SHALL NOT affect the result.
REQ-023: Results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor, for all operands with divisor != 0.

Reset
REQ-024: On sys_rst=1 at a clock edge, the FSM SHALL enter IDLE, and busy, done, quotient, remainder, dbz, the bit counter, and all internal registers SHALL clear to 0.
REQ-025: Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; a start in the first cycle after reset deasserts SHALL be accepted.

Structure
REQ-026: A shared package micro_div_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default DW/VW constants.
REQ-027: The FSM and bit counter SHALL live in one sub-module, micro_div_ctrl, which drives load/shift/subtract enables to the datapath in micro_div_unit.

Verification
REQ-028: dividend=200, divisor=7, start pulse -> after 9 cycles, done=1, quotient=28, remainder=4, dbz=0.
REQ-029: dividend=255, divisor=1 -> quotient=255, remainder=0; dividend=255, divisor=15 -> quotient=17, remainder=0.
REQ-030: dividend=5, divisor=9 -> quotient=0, remainder=5.
REQ-031: dividend=100, divisor=0 -> done 2 cycles after start, quotient=8'hFF, remainder=4'hF, dbz=1; a following 10/3 run SHALL clear dbz and give quotient=3, remainder=1.
REQ-032: Start 200/7, then pulse start with 9/2 and change the operands during RUN -> 9/2 is ignored and the result remains 28 r4; then assert sys_rst in RUN cycle 4 -> no done pulse, and all outputs are 0 the next cycle.
REQ-033: A randomized run of at least 1000 operand pairs checked against REQ-023 and REQ-019 SHALL pass.

Source files
------------

// File: rtl/micro_div_pkg.sv
// rtl/micro_div_pkg.sv - shared FSM state enum, default widths and counter sizing helper
package micro_div_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_VW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Bit counter must hold the value DW itself, hence DW+1 codes.
  function automatic int cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/micro_div_ctrl.sv
// rtl/micro_div_ctrl.sv - division sequencer: three-state FSM, bit counter, datapath enables
module micro_div_ctrl
  import micro_div_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_dvs_zero,
  input  logic i_ge,
  output logic o_load,
  output logic o_load_zero,
  output logic o_step,
  output logic o_sub,
  output logic o_finish,
  output logic o_busy,
  output logic o_done
);

  localparam int CW = cnt_width(DW);

  div_state_t    r_state;
  div_state_t    w_next;
  logic [CW-1:0] r_cnt;
  logic          r_done;

  // Next-state and enable decode; a start is refused while the done pulse is still showing.
  always_comb begin
    w_next      = r_state;
    o_load      = 1'b0;
    o_load_zero = 1'b0;
    o_step      = 1'b0;
    o_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !r_done) begin
          if (i_dvs_zero) begin
            o_load_zero = 1'b1;
            w_next      = DONE;
          end else begin
            o_load = 1'b1;
            w_next = RUN;
          end
        end
      end
      RUN: begin
        o_step = 1'b1;
        if (r_cnt == CW'(1)) begin
          w_next = DONE;
        end
      end
      DONE: begin
        o_finish = 1'b1;
        w_next   = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign o_sub  = o_step & i_ge;
  assign o_busy = (r_state != IDLE) | r_done;
  assign o_done = r_done;

  // State register, bit counter and the registered done pulse that follows DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= o_finish;
      if (o_load) begin
        r_cnt <= CW'(DW);
      end else if (o_step) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/micro_div_unit.sv
// rtl/micro_div_unit.sv - restoring unsigned divider datapath, one quotient bit per cycle
module micro_div_unit
  import micro_div_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz
);

  logic [DW-1:0] r_dvd;
  logic [VW-1:0] r_dvs;
  logic [VW-1:0] r_prem;
  logic [DW-1:0] r_quo;
  logic          r_zero;
  logic [DW-1:0] r_q_out;
  logic [VW-1:0] r_r_out;
  logic          r_dbz;

  logic [VW:0]   w_shifted;
  logic          w_ge;
  logic [VW-1:0] w_prem_next;
  logic          w_dvs_zero;
  logic          w_load;
  logic          w_load_zero;
  logic          w_step;
  logic          w_sub;
  logic          w_finish;

  // The stored partial remainder is always below the divisor, so VW bits suffice between
  // steps; the shifted value needs the extra bit before the compare.
  assign w_shifted   = {r_prem, r_dvd[DW-1]};
  assign w_ge        = (w_shifted >= {1'b0, r_dvs});
  assign w_prem_next = w_sub ? VW'(w_shifted - {1'b0, r_dvs}) : w_shifted[VW-1:0];
  assign w_dvs_zero  = (divisor == '0);

  micro_div_ctrl #(
    .DW(DW)
  ) u_ctrl (
    .i_clk       (sys_clk),
    .i_rst       (sys_rst),
    .i_start     (start),
    .i_dvs_zero  (w_dvs_zero),
    .i_ge        (w_ge),
    .o_load      (w_load),
    .o_load_zero (w_load_zero),
    .o_step      (w_step),
    .o_sub       (w_sub),
    .o_finish    (w_finish),
    .o_busy      (busy),
    .o_done      (done)
  );

  // Working registers: operand capture on accept, one restoring step per RUN cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_prem <= '0;
      r_quo  <= '0;
      r_zero <= 1'b0;
    end else if (w_load) begin
      r_dvd  <= dividend;
      r_dvs  <= divisor;
      r_prem <= '0;
      r_quo  <= '0;
      r_zero <= 1'b0;
    end else if (w_load_zero) begin
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_prem <= '0;
      r_quo  <= '0;
      r_zero <= 1'b1;
    end else if (w_step) begin
      r_dvd  <= r_dvd << 1;
      r_prem <= w_prem_next;
      r_quo  <= {r_quo[DW-2:0], w_sub};
    end
  end

  // Result registers: published alongside the done pulse, held until the next completion.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_q_out <= '0;
      r_r_out <= '0;
      r_dbz   <= 1'b0;
    end else if (w_finish) begin
      if (r_zero) begin
        r_q_out <= '1;
        r_r_out <= '1;
        r_dbz   <= 1'b1;
      end else begin
        r_q_out <= r_quo;
        r_r_out <= r_prem;
        r_dbz   <= 1'b0;
      end
    end
  end

  assign quotient  = r_q_out;
  assign remainder = r_r_out;
  assign dbz       = r_dbz;

endmodule

// File: tb/tb_micro_div_unit.sv
// tb/tb_micro_div_unit.sv - self-checking bench for micro_div_unit with behavioural model
module tb_micro_div_unit;

  localparam int DW = 8;
  localparam int VW = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          dbz;

  int checks   = 0;
  int failures = 0;

  micro_div_unit #(
    .DW(DW),
    .VW(VW)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: one operation at a time, timed by rising-edge count.
  int            edge_cnt = 0;
  bit            live     = 1'b0;
  bit            pend     = 1'b0;
  int            last_acc = -100;
  int            last_due = -100;
  logic [DW-1:0] pq;
  logic [VW-1:0] pr;
  logic          pdbz;
  logic [DW-1:0] hq       = '0;
  logic [VW-1:0] hr       = '0;
  logic          hdbz     = 1'b0;
  logic          exp_done = 1'b0;
  logic          exp_busy = 1'b0;

  initial begin
    forever begin
      @(posedge sys_clk);
      edge_cnt++;
      if (sys_rst) begin
        pend     = 1'b0;
        hq       = '0;
        hr       = '0;
        hdbz     = 1'b0;
        last_acc = -100;
        last_due = -100;
        live     = 1'b1;
      end else if (start && edge_cnt >= last_due + 2) begin
        pend     = 1'b1;
        last_acc = edge_cnt;
        if (divisor == 0) begin
          pq       = '1;
          pr       = '1;
          pdbz     = 1'b1;
          last_due = edge_cnt + 1;
        end else begin
          pq       = DW'(int'(dividend) / int'(divisor));
          pr       = VW'(int'(dividend) % int'(divisor));
          pdbz     = 1'b0;
          last_due = edge_cnt + DW + 1;
        end
      end
      exp_done = pend && (edge_cnt == last_due);
      if (exp_done) begin
        hq   = pq;
        hr   = pr;
        hdbz = pdbz;
        pend = 1'b0;
      end
      exp_busy = (edge_cnt >= last_acc) && (edge_cnt <= last_due);
    end
  end

  // Cycle-by-cycle comparison against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (live) begin
        chk("cyc_done", done, exp_done);
        chk("cyc_busy", busy, exp_busy);
        chk("cyc_quotient", quotient, hq);
        chk("cyc_remainder", remainder, hr);
        chk("cyc_dbz", dbz, hdbz);
      end
    end
  end

  task automatic op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                    input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic edbz,
                    input bit now, input bit noisy, input string tag);
    int lat;
    bit seen;
    if (!now) begin
      @(negedge sys_clk);
      #1;
    end
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    seen     = 1'b0;
    lat      = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge sys_clk);
      if (done) begin
        seen = 1'b1;
        lat  = k - 1;
      end
      #1;
      if (seen) begin
        start = 1'b0;
        break;
      end
      if (noisy) begin
        start    = 1'($urandom_range(0, 1));
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_latency"}, 32'(lat), edbz ? 32'd1 : 32'(DW + 1));
      chk({tag, "_quotient"}, quotient, eq);
      chk({tag, "_remainder"}, remainder, er);
      chk({tag, "_dbz"}, dbz, edbz);
      if (!edbz) begin
        chk({tag, "_identity"}, int'(quotient) * int'(b) + int'(remainder), int'(a));
        chk({tag, "_rem_lt_div"}, 32'(remainder < b), 32'd1);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] ra;
    logic [VW-1:0] rb;
    bit            seen;

    sys_rst  = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge sys_clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_quotient", quotient, 8'd0);
    chk("reset_remainder", remainder, 4'd0);
    chk("reset_dbz", dbz, 1'b0);
    #1;
    sys_rst = 1'b0;

    op(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 1'b1, 1'b0, "d200_7");
    op(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 1'b0, 1'b0, "d255_1");
    op(8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 1'b0, 1'b0, "d255_15");
    op(8'd5, 4'd9, 8'd0, 4'd5, 1'b0, 1'b0, 1'b0, "d5_9");
    op(8'd100, 4'd0, 8'hFF, 4'hF, 1'b1, 1'b0, 1'b0, "d100_0");
    op(8'd10, 4'd3, 8'd3, 4'd1, 1'b0, 1'b0, 1'b0, "d10_3");

    @(negedge sys_clk);
    #1;
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 4'd7;
    @(negedge sys_clk);
    #1;
    start = 1'b0;
    @(negedge sys_clk);
    #1;
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 4'd2;
    @(negedge sys_clk);
    #1;
    start    = 1'b0;
    dividend = 8'd3;
    divisor  = 4'd1;
    seen     = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge sys_clk);
      if (done) seen = 1'b1;
    end
    chk("ignore_done_seen", 32'(seen), 32'd1);
    chk("ignore_quotient", quotient, 8'd28);
    chk("ignore_remainder", remainder, 4'd4);

    repeat (2) @(negedge sys_clk);
    #1;
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 4'd7;
    @(negedge sys_clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("abort_done", done, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_quotient", quotient, 8'd0);
    chk("abort_remainder", remainder, 4'd0);
    chk("abort_dbz", dbz, 1'b0);
    #1;
    sys_rst = 1'b0;
    op(8'd10, 4'd3, 8'd3, 4'd1, 1'b0, 1'b1, 1'b0, "post_reset");

    for (int i = 0; i < 1000; i++) begin
      ra = DW'($urandom);
      rb = VW'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge sys_clk);
      if (rb == 0) begin
        op(ra, rb, '1, '1, 1'b1, 1'b0, 1'($urandom_range(0, 1)), "rand");
      end else begin
        op(ra, rb, DW'(int'(ra) / int'(rb)), VW'(int'(ra) % int'(rb)), 1'b0, 1'b0,
           1'($urandom_range(0, 1)), "rand");
      end
    end

    repeat (3) @(negedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
